phase_monitor: RTL and testbench
================================

PHASE_MONITOR -- requirements
Module: phase_monitor

Interface
REQ-001 SHALL have parameter: LOCK_CYCLES, default 8, consecutive in-sequence samples needed to lock (legal range 2..15).
REQ-002 SHALL have port: clk12  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: phi1, phi2, phi3, phi4  input  1 each  active-low 4-phase clock phases.
REQ-005 SHALL have port: err_clr  input  1  synchronous clear of err_count.
REQ-006 SHALL have port: phase  output  2  index of last legal phase sampled (0=phi1 … 3=phi4).
REQ-007 SHALL have port: phase_valid  output  1  last sample was legal.
REQ-008 SHALL have port: locked  output  1  monitor in LOCKED state.
REQ-009 SHALL have port: err  output  1  one-cycle pulse on loss of lock.
REQ-010 SHALL have port: err_count  output  8  saturating count of lock losses.

Function
REQ-011 SHALL sample phi1..phi4 on each clk12 rising edge; all outputs registered, reflecting that edge's sample (1-cycle latency).
REQ-012 Sample SHALL be legal iff exactly one phi is low; idx = position of the low phi.
REQ-013 phase_valid SHALL equal legality of the current sample; phase SHALL update to idx only on legal samples, else hold.
REQ-014 In-sequence SHALL mean legal and idx == (last_idx + 1) mod 4, wrapping 3→0.
REQ-015 FSM states SHALL be HUNT, SYNC, LOCKED; registers last_idx (2 bits) and good_cnt (4 bits).
REQ-016 HUNT: legal → SYNC, good_cnt=1, last_idx=idx; illegal → stay HUNT.
REQ-017 SYNC: in-sequence → good_cnt+1, last_idx=idx; when good_cnt+1 == LOCK_CYCLES → LOCKED.
REQ-018 SYNC: legal out-of-sequence (incl. repeated phase) → stay SYNC, good_cnt=1, last_idx=idx; illegal → HUNT, good_cnt=0.
REQ-019 SYNC exits SHALL NOT assert err nor change err_count.
REQ-020 LOCKED: in-sequence → stay, last_idx=idx.
REQ-021 LOCKED: legal out-of-sequence → SYNC, good_cnt=1, last_idx=idx, err=1 for one cycle.
REQ-022 LOCKED: illegal → HUNT, good_cnt=0, err=1 for one cycle.
REQ-023 locked SHALL be 1 exactly while state is LOCKED, asserting the cycle after the LOCK_CYCLES-th in-sequence sample is registered.
REQ-024 err_count SHALL increment on each err pulse, saturating at 255.
REQ-025 err_clr SHALL set err_count to 0; err_clr and err in the same cycle SHALL yield err_count=1.

Reset
REQ-026 reset SHALL force: state=HUNT, good_cnt=0, last_idx=0, phase=0, phase_valid=0, locked=0, err=0, err_count=0.
REQ-027 reset SHALL take priority over all inputs, including mid-lock; monitoring resumes from HUNT the cycle after deassertion.

Structure
REQ-028 Package phase_monitor_pkg SHALL hold the state enum (HUNT, SYNC, LOCKED), phase index width (2), and err_count width (8).
REQ-029 A single combinational sub-module phase_decode SHALL map phi1..phi4 to {legal, idx}; all state lives in phase_monitor.

Verification
REQ-030 clockgen driven from clk12 bench clock, LOCK_CYCLES=8, reset released → locked=1 after 8 legal samples, phase cycles 0,1,2,3,0…, err never asserts.
REQ-031 Locked, then force all phi high for 1 cycle → err pulses once, err_count=1, locked=0, state HUNT; resumed clockgen relocks after 8 samples.
REQ-032 Locked, drive phase sequence 0,1,2,2 (repeat) → err pulse on the repeat, state SYNC with good_cnt=1, no second err.
REQ-033 Drive 0,1,0,1 repeatedly from reset → never locks, err stays 0, err_count stays 0.
REQ-034 Force 260 lock losses → err_count saturates at 255; err_clr coincident with a loss → err_count=1.
REQ-035 Assert reset for 1 cycle while locked with err_count=5 → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/phase_monitor_pkg.sv
// Shared types and widths for the 4-phase clock monitor.
// The decoder and the monitor FSM both import this package.
package phase_monitor_pkg;

   localparam int IDX_W = 2;
   localparam int ERR_W = 8;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Phase that must follow idx in a healthy rotation (3 wraps to 0).
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      return idx + 1'b1;
   endfunction

endpackage

// File: rtl/phase_monitor_decode.sv
// Combinational decode of the four active-low phases into {legal, idx}.
// A sample is legal only when exactly one phase is low.
module phase_decode
   import phase_monitor_pkg::*;
(
   input  logic             phi1,
   input  logic             phi2,
   input  logic             phi3,
   input  logic             phi4,
   output logic             legal,
   output logic [IDX_W-1:0] idx
);

   logic [3:0] low;

   assign low = ~{phi4, phi3, phi2, phi1};

   always_comb begin
      legal = 1'b1;
      idx   = '0;
      case (low)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/phase_monitor.sv
// Lock monitor for a 4-phase active-low clock sampled on clk12.
// All outputs are registered and describe the sample taken at the previous edge.
module phase_monitor
   import phase_monitor_pkg::*;
#(
   parameter int LOCK_CYCLES = 8
)
(
   input  logic             clk12,
   input  logic             reset,
   input  logic             phi1,
   input  logic             phi2,
   input  logic             phi3,
   input  logic             phi4,
   input  logic             err_clr,
   output logic [IDX_W-1:0] phase,
   output logic             phase_valid,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_count,
   output logic [1:0]       dbg_state,
   output logic [CNT_W-1:0] dbg_good_cnt
);

   localparam logic [CNT_W-1:0] LOCK_N  = CNT_W'(LOCK_CYCLES);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   logic             legal;
   logic [IDX_W-1:0] idx;
   logic             in_seq;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
   logic [IDX_W-1:0] last_idx_q, last_idx_d;
   logic [IDX_W-1:0] phase_q, phase_d;
   logic             phase_valid_q, phase_valid_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;

   phase_decode u_decode (
      .phi1  (phi1),
      .phi2  (phi2),
      .phi3  (phi3),
      .phi4  (phi4),
      .legal (legal),
      .idx   (idx)
   );

   assign in_seq = legal && (idx == next_idx(last_idx_q));

   always_comb begin
      state_d       = state_q;
      good_cnt_d    = good_cnt_q;
      last_idx_d    = last_idx_q;
      err_d         = 1'b0;
      phase_valid_d = legal;
      phase_d       = legal ? idx : phase_q;

      case (state_q)
         HUNT: begin
            if (legal) begin
               state_d    = SYNC;
               good_cnt_d = 4'd1;
               last_idx_d = idx;
            end
         end
         SYNC: begin
            if (!legal) begin
               state_d    = HUNT;
               good_cnt_d = '0;
            end else if (in_seq) begin
               good_cnt_d = good_cnt_q + 4'd1;
               last_idx_d = idx;
               if (good_cnt_q + 4'd1 == LOCK_N) begin
                  state_d = LOCKED;
               end
            end else begin
               // Repeated or skipped phase restarts the run without flagging an error.
               good_cnt_d = 4'd1;
               last_idx_d = idx;
            end
         end
         LOCKED: begin
            if (!legal) begin
               state_d    = HUNT;
               good_cnt_d = '0;
               err_d      = 1'b1;
            end else if (in_seq) begin
               last_idx_d = idx;
            end else begin
               state_d    = SYNC;
               good_cnt_d = 4'd1;
               last_idx_d = idx;
               err_d      = 1'b1;
            end
         end
         default: begin
            state_d    = HUNT;
            good_cnt_d = '0;
         end
      endcase

      locked_d = (state_d == LOCKED);

      // A clear that coincides with a new loss still records that loss.
      err_count_d = err_count_q;
      if (err_clr) begin
         err_count_d = err_d ? ERR_W'(1) : '0;
      end else if (err_d && err_count_q != ERR_MAX) begin
         err_count_d = err_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk12) begin
      if (reset) begin
         state_q       <= HUNT;
         good_cnt_q    <= '0;
         last_idx_q    <= '0;
         phase_q       <= '0;
         phase_valid_q <= 1'b0;
         locked_q      <= 1'b0;
         err_q         <= 1'b0;
         err_count_q   <= '0;
      end else begin
         state_q       <= state_d;
         good_cnt_q    <= good_cnt_d;
         last_idx_q    <= last_idx_d;
         phase_q       <= phase_d;
         phase_valid_q <= phase_valid_d;
         locked_q      <= locked_d;
         err_q         <= err_d;
         err_count_q   <= err_count_d;
      end
   end

   assign phase        = phase_q;
   assign phase_valid  = phase_valid_q;
   assign locked       = locked_q;
   assign err          = err_q;
   assign err_count    = err_count_q;
   assign dbg_state    = state_q;
   assign dbg_good_cnt = good_cnt_q;

endmodule

// File: tb/tb_phase_monitor.sv
// Directed bench for phase_monitor: the driver queues the expected registered
// outputs for every sample and an independent monitor compares them one edge later.
module tb_phase_monitor;
   import phase_monitor_pkg::*;

   localparam int EW = 19;

   logic       clk12 = 1'b0;
   logic       reset;
   logic       phi1, phi2, phi3, phi4;
   logic       err_clr;
   logic [1:0] phase;
   logic       phase_valid;
   logic       locked;
   logic       err;
   logic [7:0] err_count;
   logic [1:0] dbg_state;
   logic [3:0] dbg_good_cnt;

   logic [EW-1:0] exp_q[$];
   string         tag_q[$];
   int            checks   = 0;
   int            failures = 0;
   int            exp_last = 0;
   int            exp_cnt  = 0;

   always #5 clk12 = ~clk12;

   phase_monitor #(.LOCK_CYCLES(8)) dut (
      .clk12        (clk12),
      .reset        (reset),
      .phi1         (phi1),
      .phi2         (phi2),
      .phi3         (phi3),
      .phi4         (phi4),
      .err_clr      (err_clr),
      .phase        (phase),
      .phase_valid  (phase_valid),
      .locked       (locked),
      .err          (err),
      .err_count    (err_count),
      .dbg_state    (dbg_state),
      .dbg_good_cnt (dbg_good_cnt)
   );

   function automatic logic [EW-1:0] pack(input logic [1:0] ph, input logic v, input logic lk,
                                          input logic e, input logic [7:0] c, input state_t s,
                                          input logic [3:0] g);
      return {ph, v, lk, e, c, 2'(s), g};
   endfunction

   function automatic logic [3:0] phi_of(input int i);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << (i % 4));
   endfunction

   task automatic step(input logic [3:0] pn, input logic clr, input logic rst,
                       input logic [EW-1:0] e, input string t);
      @(negedge clk12);
      {phi4, phi3, phi2, phi1} = pn;
      err_clr = clr;
      reset   = rst;
      exp_q.push_back(e);
      tag_q.push_back(t);
   endtask

   task automatic do_reset(input string t);
      step(4'hF, 1'b0, 1'b1, pack(2'd0, 1'b0, 1'b0, 1'b0, 8'd0, HUNT, 4'd0), t);
      exp_cnt  = 0;
      exp_last = 0;
   endtask

   // Eight consecutive phases starting at 'start', entered from HUNT.
   task automatic acquire(input int start);
      for (int n = 1; n <= 8; n++) begin
         int i;
         i = start + n - 1;
         step(phi_of(i), 1'b0, 1'b0,
              pack(2'(i % 4), 1'b1, n == 8, 1'b0, 8'(exp_cnt), (n == 8) ? LOCKED : SYNC, 4'(n)),
              "acquire");
      end
      exp_last = (start + 7) % 4;
   endtask

   // Repeat the last phase while locked (one loss), then relock with 7 more phases.
   task automatic loss_relock();
      if (exp_cnt < 255) exp_cnt++;
      step(phi_of(exp_last), 1'b0, 1'b0,
           pack(2'(exp_last), 1'b1, 1'b0, 1'b1, 8'(exp_cnt), SYNC, 4'd1), "loss_err");
      for (int n = 2; n <= 8; n++) begin
         int i;
         i = exp_last + n - 1;
         step(phi_of(i), 1'b0, 1'b0,
              pack(2'(i % 4), 1'b1, n == 8, 1'b0, 8'(exp_cnt), (n == 8) ? LOCKED : SYNC, 4'(n)),
              "relock");
      end
      exp_last = (exp_last + 7) % 4;
   endtask

   initial begin
      forever begin
         logic [EW-1:0] e, a;
         string         t;
         @(posedge clk12);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {phase, phase_valid, locked, err, err_count, dbg_state, dbg_good_cnt};
            checks++;
            if (a !== e) begin
               failures++;
               $display("FAIL %s: got ph=%0d v=%0d lk=%0d err=%0d cnt=%0d st=%0d gc=%0d, exp ph=%0d v=%0d lk=%0d err=%0d cnt=%0d st=%0d gc=%0d",
                        t, a[18:17], a[16], a[15], a[14], a[13:6], a[5:4], a[3:0],
                        e[18:17], e[16], e[15], e[14], e[13:6], e[5:4], e[3:0]);
            end
         end
      end
   end

   initial begin
      reset   = 1'b1;
      err_clr = 1'b0;
      {phi4, phi3, phi2, phi1} = 4'hF;

      do_reset("reset_a");
      do_reset("reset_b");

      step(4'b1100, 1'b0, 1'b0, pack(2'd0, 1'b0, 1'b0, 1'b0, 8'd0, HUNT, 4'd0), "two_low");
      step(4'b0000, 1'b0, 1'b0, pack(2'd0, 1'b0, 1'b0, 1'b0, 8'd0, HUNT, 4'd0), "all_low");
      step(4'hF,    1'b0, 1'b0, pack(2'd0, 1'b0, 1'b0, 1'b0, 8'd0, HUNT, 4'd0), "all_high");

      // Clean rotation locks after 8 samples and keeps cycling without error.
      acquire(0);
      for (int i = 8; i < 12; i++) begin
         step(phi_of(i), 1'b0, 1'b0, pack(2'(i % 4), 1'b1, 1'b1, 1'b0, 8'd0, LOCKED, 4'd8), "locked_run");
      end
      exp_last = 3;

      // All phases high while locked: one error, drop to HUNT, then relock.
      exp_cnt = 1;
      step(4'hF, 1'b0, 1'b0, pack(2'd3, 1'b0, 1'b0, 1'b1, 8'd1, HUNT, 4'd0), "drop_all_high");
      step(4'hF, 1'b0, 1'b0, pack(2'd3, 1'b0, 1'b0, 1'b0, 8'd1, HUNT, 4'd0), "hunt_hold");
      acquire(0);

      // Repeated phase while locked: single error, back to SYNC with a run of one.
      step(phi_of(0), 1'b0, 1'b0, pack(2'd0, 1'b1, 1'b1, 1'b0, 8'd1, LOCKED, 4'd8), "seq_0");
      step(phi_of(1), 1'b0, 1'b0, pack(2'd1, 1'b1, 1'b1, 1'b0, 8'd1, LOCKED, 4'd8), "seq_1");
      step(phi_of(2), 1'b0, 1'b0, pack(2'd2, 1'b1, 1'b1, 1'b0, 8'd1, LOCKED, 4'd8), "seq_2");
      step(phi_of(2), 1'b0, 1'b0, pack(2'd2, 1'b1, 1'b0, 1'b1, 8'd2, SYNC, 4'd1), "repeat_err");
      step(phi_of(2), 1'b0, 1'b0, pack(2'd2, 1'b1, 1'b0, 1'b0, 8'd2, SYNC, 4'd1), "repeat_again");
      step(phi_of(3), 1'b0, 1'b0, pack(2'd3, 1'b1, 1'b0, 1'b0, 8'd2, SYNC, 4'd2), "resync");

      // Ping-pong between phi1 and phi2 never locks and never errors.
      do_reset("reset_c");
      for (int k = 0; k < 16; k++) begin
         step(phi_of(k % 2), 1'b0, 1'b0,
              pack(2'(k % 2), 1'b1, 1'b0, 1'b0, 8'd0, SYNC, (k % 2 == 0) ? 4'd1 : 4'd2), "alt_01");
      end

      // 260 losses saturate the counter; clear coincident with a loss leaves 1.
      do_reset("reset_d");
      acquire(0);
      for (int k = 0; k < 260; k++) loss_relock();
      step(phi_of(exp_last), 1'b1, 1'b0,
           pack(2'(exp_last), 1'b1, 1'b0, 1'b1, 8'd1, SYNC, 4'd1), "clr_with_err");
      step(phi_of(exp_last + 1), 1'b0, 1'b0,
           pack(2'((exp_last + 1) % 4), 1'b1, 1'b0, 1'b0, 8'd1, SYNC, 4'd2), "post_clr");
      step(phi_of(exp_last + 2), 1'b1, 1'b0,
           pack(2'((exp_last + 2) % 4), 1'b1, 1'b0, 1'b0, 8'd0, SYNC, 4'd3), "clr_alone");

      // Reset while locked with five recorded losses.
      do_reset("reset_e");
      acquire(0);
      for (int k = 0; k < 5; k++) loss_relock();
      do_reset("reset_locked");
      step(phi_of(2), 1'b0, 1'b0, pack(2'd2, 1'b1, 1'b0, 1'b0, 8'd0, SYNC, 4'd1), "resume");

      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         @(posedge clk12);
         #2;
      end
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: got %0d pending expectations, exp 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
